// File: rtl/rans_enc_lanes.sv
// rANS encoder with N_LANES round-robin interleaved states, byte-wise renormalisation,
// a bit-serial restoring divider and an end-of-block flush of every lane state.
module rans_enc_lanes #(
  parameter int RESOLUTION  = 10,
  parameter int N_LANES     = 2,
  parameter int STATE_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sym_valid,
  output logic                  sym_ready,
  input  logic [RESOLUTION:0]   sym_freq,
  input  logic [RESOLUTION-1:0] sym_cum,
  input  logic                  sym_last,
  output logic                  sym_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last
);

  localparam int SW = STATE_WIDTH;
  localparam int RW = RESOLUTION;
  localparam int NB = SW / 8;
  localparam int LW = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int BW = $clog2(NB);
  localparam int CW = $clog2(SW);

  localparam logic [SW-1:0] L_VAL     = {8'h01, {(SW-8){1'b0}}};
  localparam logic [LW-1:0] LAST_LANE = LW'(N_LANES - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(NB - 1);
  localparam logic [BW-1:0] PEN_BYTE  = BW'(NB - 2);
  localparam logic [CW-1:0] LAST_STEP = CW'(SW - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REJ, S_RENORM, S_DIV, S_UPDATE, S_FLUSH
  } state_t;

  // x_max = freq << (SW - RESOLUTION), one bit wider than the state so freq = M fits
  function automatic logic [SW:0] x_max(input logic [RW:0] f);
    return {f, {(SW-RW){1'b0}}};
  endfunction

  state_t          state_reg;
  logic [SW-1:0]   lane_reg [N_LANES];
  logic [LW-1:0]   lane_ptr_reg;
  logic [SW-1:0]   x_reg;
  logic [RW:0]     freq_reg;
  logic [RW-1:0]   cum_reg;
  logic            last_reg;
  logic [RW-1:0]   rem_reg;
  logic [CW-1:0]   step_reg;
  logic [LW-1:0]   flush_lane_reg;
  logic [BW-1:0]   flush_byte_reg;
  logic            sym_ready_reg;
  logic            sym_err_reg;
  logic            out_valid_reg;
  logic [7:0]      out_data_reg;
  logic            out_last_reg;

  logic [RW:0]     trial;
  logic            div_ge;
  logic [RW-1:0]   rem_diff;
  logic [RW-1:0]   rem_next;
  logic [SW-1:0]   x_new;
  logic [SW-1:0]   x_shift;
  logic [SW-1:0]   lane_cur;
  logic [SW-1:0]   flush_top;
  logic [LW-1:0]   flush_lane_dec;
  logic [SW-1:0]   flush_next_lane;
  logic            go_flush;
  logic            out_hs;

  // x_reg is the working state in RENORM, the dividend/quotient in DIV and the
  // byte shift register in FLUSH
  assign trial           = {rem_reg, x_reg[SW-1]};
  assign div_ge          = (trial >= freq_reg);
  assign rem_diff        = trial[RW-1:0] - freq_reg[RW-1:0];
  assign rem_next        = div_ge ? rem_diff : trial[RW-1:0];
  assign x_new           = {x_reg[SW-RW-1:0], {RW{1'b0}}} + {{(SW-RW){1'b0}}, rem_reg}
                         + {{(SW-RW){1'b0}}, cum_reg};
  assign x_shift         = x_reg >> 8;
  assign lane_cur        = lane_reg[lane_ptr_reg];
  assign flush_top       = (state_reg == S_UPDATE && lane_ptr_reg == LAST_LANE) ? x_new
                                                                             : lane_reg[LAST_LANE];
  assign flush_lane_dec  = flush_lane_reg - LW'(1);
  assign flush_next_lane = lane_reg[flush_lane_dec];
  assign go_flush        = last_reg && (state_reg == S_REJ || state_reg == S_UPDATE);
  assign out_hs          = out_valid_reg & out_ready;

  assign sym_ready = sym_ready_reg;
  assign sym_err   = sym_err_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= S_IDLE;
      for (int i = 0; i < N_LANES; i++) lane_reg[i] <= L_VAL;
      lane_ptr_reg   <= '0;
      x_reg          <= '0;
      freq_reg       <= '0;
      cum_reg        <= '0;
      last_reg       <= 1'b0;
      rem_reg        <= '0;
      step_reg       <= '0;
      flush_lane_reg <= '0;
      flush_byte_reg <= '0;
      sym_ready_reg  <= 1'b0;
      sym_err_reg    <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_data_reg   <= '0;
      out_last_reg   <= 1'b0;
    end else begin
      sym_err_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          sym_ready_reg <= 1'b1;
          if (sym_ready_reg && sym_valid) begin
            sym_ready_reg <= 1'b0;
            freq_reg      <= sym_freq;
            cum_reg       <= sym_cum;
            last_reg      <= sym_last;
            x_reg         <= lane_cur;
            if (sym_freq == '0) begin
              state_reg   <= S_REJ;
              sym_err_reg <= 1'b1;
            end else begin
              // first renorm byte is presented on the cycle RENORM is entered
              state_reg     <= S_RENORM;
              out_valid_reg <= ({1'b0, lane_cur} >= x_max(sym_freq));
              out_data_reg  <= lane_cur[7:0];
            end
          end
        end
        S_REJ: begin
          state_reg     <= S_IDLE;
          sym_ready_reg <= 1'b1;
        end
        S_RENORM: begin
          if (out_valid_reg) begin
            if (out_ready) begin
              x_reg         <= x_shift;
              out_valid_reg <= ({1'b0, x_shift} >= x_max(freq_reg));
              out_data_reg  <= x_shift[7:0];
            end
          end else begin
            state_reg <= S_DIV;
            rem_reg   <= '0;
            step_reg  <= '0;
          end
        end
        S_DIV: begin
          x_reg    <= {x_reg[SW-2:0], div_ge};
          rem_reg  <= rem_next;
          step_reg <= step_reg + CW'(1);
          if (step_reg == LAST_STEP) state_reg <= S_UPDATE;
        end
        S_UPDATE: begin
          lane_reg[lane_ptr_reg] <= x_new;
          lane_ptr_reg  <= (lane_ptr_reg == LAST_LANE) ? '0 : lane_ptr_reg + LW'(1);
          state_reg     <= S_IDLE;
          sym_ready_reg <= 1'b1;
        end
        S_FLUSH: begin
          if (out_hs) begin
            if (out_last_reg) begin
              for (int i = 0; i < N_LANES; i++) lane_reg[i] <= L_VAL;
              lane_ptr_reg  <= '0;
              out_valid_reg <= 1'b0;
              out_last_reg  <= 1'b0;
              state_reg     <= S_IDLE;
              sym_ready_reg <= 1'b1;
            end else if (flush_byte_reg == LAST_BYTE) begin
              flush_lane_reg <= flush_lane_dec;
              flush_byte_reg <= '0;
              x_reg          <= flush_next_lane;
              out_data_reg   <= flush_next_lane[7:0];
            end else begin
              x_reg          <= x_shift;
              flush_byte_reg <= flush_byte_reg + BW'(1);
              out_data_reg   <= x_shift[7:0];
              out_last_reg   <= (flush_lane_reg == '0) && (flush_byte_reg == PEN_BYTE);
            end
          end
        end
        default: begin
          state_reg     <= S_IDLE;
          sym_ready_reg <= 1'b0;
        end
      endcase

      // last symbol (accepted or rejected): start emitting from the highest lane
      if (go_flush) begin
        state_reg      <= S_FLUSH;
        sym_ready_reg  <= 1'b0;
        flush_lane_reg <= LAST_LANE;
        flush_byte_reg <= '0;
        x_reg          <= flush_top;
        out_valid_reg  <= 1'b1;
        out_data_reg   <= flush_top[7:0];
        out_last_reg   <= 1'b0;
      end
    end
  end

endmodule
